am_sweep_ctrl: RTL and testbench
================================

AM_SWEEP_CTRL -- requirements
Module: am_sweep_ctrl

Interface
REQ-001 Parameter DWELL_W, default 16, width of the dwell-length input and dwell counter.
REQ-002 clk  input  1  system clock, 125 MHz.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 pls  input  1  one-clk sample strobe, 500 kHz; dwell time base.
REQ-005 start  input  1  one-clk request to begin a sweep.
REQ-006 abort  input  1  one-clk request to stop a sweep.
REQ-007 indx_lo, indx_hi, indx_step  input  8 each  modulation-index sweep bounds and increment.
REQ-008 f_lo, f_hi, f_step  input  16 each  source-frequency sweep bounds and increment.
REQ-009 dwell_len  input  DWELL_W  pls pulses spent at each (index, frequency) point.
REQ-010 indx_set  output  8  modulation index driven to the AM index-set datapath.
REQ-011 f_source  output  16  frequency word driven to the source sine generator.
REQ-012 upd  output  1  one-clk pulse whenever indx_set or f_source changes value.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-clk pulse on normal sweep completion.

Function
REQ-015 The FSM SHALL have exactly five states: IDLE, LOAD, DWELL, STEP, FIN.
REQ-016 In IDLE, start=1 and abort=0 SHALL move the FSM to LOAD; start has no effect in any other state.
REQ-017 In LOAD, the block SHALL latch all bound, step and dwell inputs into shadow registers, set indx_set=indx_lo and f_source=f_lo, pulse upd, clear the dwell counter and go to DWELL; LOAD lasts exactly one clk.
REQ-018 In DWELL, the counter SHALL increment only on clks with pls=1; when it reaches max(dwell_len,1) the FSM SHALL go to STEP on the next clk. dwell_len=0 is treated as 1.
REQ-019 In STEP, when indx_set+indx_step (9-bit sum) <= indx_hi, the block SHALL set indx_set to the sum and return to DWELL.
REQ-020 Otherwise, when f_source+f_step (17-bit sum) <= f_hi, the block SHALL set indx_set=indx_lo and f_source to the sum, then return to DWELL.
REQ-021 Otherwise, the block SHALL go to FIN and leave both outputs unchanged.
REQ-022 Every STEP transition back to DWELL SHALL pulse upd in the same clk the outputs change, and SHALL clear the dwell counter.
REQ-023 indx_step=0 SHALL behave as a step of 1; f_step=0 SHALL end the sweep after the first index pass (FIN).
REQ-024 indx_lo>indx_hi or f_lo>f_hi SHALL be legal: one point at (indx_lo, f_lo) is dwelt, then FIN.
REQ-025 FIN SHALL pulse done for one clk and return to IDLE on the next clk.
REQ-026 abort=1 in any non-IDLE state SHALL force IDLE on the next clk, with no done pulse and no upd pulse; indx_set and f_source hold their last values.
REQ-027 When abort and start are both 1, abort SHALL win.
REQ-028 Input changes during a sweep SHALL have no effect until the next LOAD.
REQ-029 All outputs SHALL be registered; f_source and indx_set SHALL appear one clk after the corresponding state decision.

Reset
REQ-030 Reset SHALL force: state=IDLE, indx_set=0, f_source=0, upd=0, busy=0, done=0, dwell counter=0, shadow registers=0.
REQ-031 Reset asserted mid-sweep SHALL override all other inputs in that clk, including start and abort.

Structure
REQ-032 The state encoding, the 8/16-bit index and frequency widths, and the DWELL_W default SHALL live in the shared package am_pkg.
REQ-033 The pls-gated dwell counter SHALL be the single sub-module am_dwell_cnt, with ports: clear, pls, len, expire.
REQ-034 The block SHALL contain no arithmetic wider than 17 bits and no multipliers.

Verification
REQ-035 Basic sweep: indx 10..30 step 10, f 100..200 step 100, dwell 2 -> points (10,100) (20,100) (30,100) (10,200) (20,200) (30,200), each held 2 pls, six upd pulses, one done pulse.
REQ-036 Index overflow: indx_lo=250, indx_hi=255, step=10, f_lo=f_hi=5 -> single point (250,5), then done; no wrap to 4.
REQ-037 Abort: abort one clk after the second upd of REQ-035 -> IDLE next clk, outputs hold (20,100), busy=0, no done pulse.
REQ-038 Simultaneous start+abort in IDLE -> FSM stays in IDLE, no upd pulse.
REQ-039 Reset mid-DWELL -> all outputs 0 next clk; a following start runs a full sweep cleanly.
REQ-040 dwell_len=0 with pls every 250 clk -> each point held exactly one pls.

Source files
------------

// File: rtl/am_pkg.sv
`default_nettype none
// ============================================================================
// Module   : am_pkg
// Brief    : Shared widths and state encoding for the AM index/frequency sweep.
// Revision : 1.0
// ============================================================================
package am_pkg;

    localparam int c_idx_w       = 8;
    localparam int c_freq_w      = 16;
    localparam int c_dwell_w_def = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DWELL = 3'd2,
        ST_STEP  = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/am_dwell_cnt.sv
`default_nettype none
// ============================================================================
// Module   : am_dwell_cnt
// Brief    : Counts pls strobes up to max(len,1) and flags expiry.
// Revision : 1.0
// ============================================================================
module am_dwell_cnt
    import am_pkg::*;
#(
    parameter int DWELL_W = c_dwell_w_def
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               pls,
    input  logic [DWELL_W-1:0] len,
    output logic               expire
);

    localparam logic [DWELL_W-1:0] c_one = DWELL_W'(1);

    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] w_len_eff;

    // A zero length still dwells for one strobe.
    assign w_len_eff = (len == '0) ? c_one : len;
    assign expire    = (r_cnt == w_len_eff);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (pls && !expire) begin
            r_cnt <= r_cnt + c_one;
        end
    end

endmodule
`default_nettype wire

// File: rtl/am_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : am_sweep_ctrl
// Brief    : Sweeps AM modulation index (inner) and source frequency (outer).
// Revision : 1.0
// ============================================================================
module am_sweep_ctrl
    import am_pkg::*;
#(
    parameter int DWELL_W = c_dwell_w_def
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pls,
    input  logic                start,
    input  logic                abort,
    input  logic [c_idx_w-1:0]  indx_lo,
    input  logic [c_idx_w-1:0]  indx_hi,
    input  logic [c_idx_w-1:0]  indx_step,
    input  logic [c_freq_w-1:0] f_lo,
    input  logic [c_freq_w-1:0] f_hi,
    input  logic [c_freq_w-1:0] f_step,
    input  logic [DWELL_W-1:0]  dwell_len,
    output logic [c_idx_w-1:0]  indx_set,
    output logic [c_freq_w-1:0] f_source,
    output logic                upd,
    output logic                busy,
    output logic                done
);

    state_t              r_state;
    logic [c_idx_w-1:0]  r_indx_set, r_ilo, r_ihi, r_istep;
    logic [c_freq_w-1:0] r_f_source, r_flo, r_fhi, r_fstep;
    logic [DWELL_W-1:0]  r_dwell;
    logic                r_upd, r_busy, r_done;

    state_t              w_state_nxt;
    logic [c_idx_w-1:0]  w_indx_nxt, w_istep_eff;
    logic [c_freq_w-1:0] w_f_nxt;
    logic [c_idx_w:0]    w_isum;
    logic [c_freq_w:0]   w_fsum;
    logic                w_upd_nxt, w_load, w_expire, w_range_ok;

    am_dwell_cnt #(
        .DWELL_W (DWELL_W)
    ) u_dwell_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (r_state != ST_DWELL),
        .pls    (pls),
        .len    (r_dwell),
        .expire (w_expire)
    );

    assign w_istep_eff = (r_istep == '0) ? c_idx_w'(1) : r_istep;
    assign w_isum      = {1'b0, r_indx_set} + {1'b0, w_istep_eff};
    assign w_fsum      = {1'b0, r_f_source} + {1'b0, r_fstep};
    // An inverted range on either axis collapses the sweep to its first point.
    assign w_range_ok  = (r_ilo <= r_ihi) && (r_flo <= r_fhi);

    always_comb begin
        w_state_nxt = r_state;
        w_indx_nxt  = r_indx_set;
        w_f_nxt     = r_f_source;
        w_upd_nxt   = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_load      = 1'b1;
                w_indx_nxt  = indx_lo;
                w_f_nxt     = f_lo;
                w_upd_nxt   = 1'b1;
                w_state_nxt = ST_DWELL;
            end
            ST_DWELL: begin
                if (w_expire) w_state_nxt = ST_STEP;
            end
            ST_STEP: begin
                if (!w_range_ok) begin
                    w_state_nxt = ST_FIN;
                end else if (w_isum <= {1'b0, r_ihi}) begin
                    w_indx_nxt  = w_isum[c_idx_w-1:0];
                    w_upd_nxt   = 1'b1;
                    w_state_nxt = ST_DWELL;
                end else if ((r_fstep != '0) && (w_fsum <= {1'b0, r_fhi})) begin
                    w_indx_nxt  = r_ilo;
                    w_f_nxt     = w_fsum[c_freq_w-1:0];
                    w_upd_nxt   = 1'b1;
                    w_state_nxt = ST_DWELL;
                end else begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Abort freezes the outputs where they are and drops straight to idle.
        if (abort && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_indx_nxt  = r_indx_set;
            w_f_nxt     = r_f_source;
            w_upd_nxt   = 1'b0;
            w_load      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_indx_set <= '0;
            r_f_source <= '0;
            r_upd      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ilo      <= '0;
            r_ihi      <= '0;
            r_istep    <= '0;
            r_flo      <= '0;
            r_fhi      <= '0;
            r_fstep    <= '0;
            r_dwell    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_indx_set <= w_indx_nxt;
            r_f_source <= w_f_nxt;
            r_upd      <= w_upd_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= (w_state_nxt == ST_FIN);
            if (w_load) begin
                r_ilo   <= indx_lo;
                r_ihi   <= indx_hi;
                r_istep <= indx_step;
                r_flo   <= f_lo;
                r_fhi   <= f_hi;
                r_fstep <= f_step;
                r_dwell <= dwell_len;
            end
        end
    end

    assign indx_set = r_indx_set;
    assign f_source = r_f_source;
    assign upd      = r_upd;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_am_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_am_sweep_ctrl
// Brief    : Directed self-checking bench for am_sweep_ctrl.
// Revision : 1.0
// ============================================================================
module tb_am_sweep_ctrl;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst, pls, start, abort;
    logic [7:0]    indx_lo, indx_hi, indx_step;
    logic [15:0]   f_lo, f_hi, f_step;
    logic [DW-1:0] dwell_len;
    logic [7:0]    indx_set;
    logic [15:0]   f_source;
    logic          upd, busy, done;

    am_sweep_ctrl #(.DWELL_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .pls       (pls),
        .start     (start),
        .abort     (abort),
        .indx_lo   (indx_lo),
        .indx_hi   (indx_hi),
        .indx_step (indx_step),
        .f_lo      (f_lo),
        .f_hi      (f_hi),
        .f_step    (f_step),
        .dwell_len (dwell_len),
        .indx_set  (indx_set),
        .f_source  (f_source),
        .upd       (upd),
        .busy      (busy),
        .done      (done)
    );

    always #4 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // pls generator: one-clk strobe every pls_period clocks (0 = off)
    int pls_period = 0;
    int pls_cnt    = 0;
    initial begin
        pls = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (pls_period == 0) begin
                pls     = 1'b0;
                pls_cnt = 0;
            end else begin
                pls     = (pls_cnt == 0);
                pls_cnt = (pls_cnt + 1) % pls_period;
            end
        end
    end

    // Monitor: record each updated point and the pls strobes seen while it is held
    int         upd_cnt = 0, done_cnt = 0, cur_pls = 0;
    logic [7:0]  pt_i[$];
    logic [15:0] pt_f[$];
    int          pt_p[$];
    int          exp_i[$];
    int          exp_f[$];

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            pt_p.push_back(cur_pls);
        end
        if (upd) begin
            if (upd_cnt > 0) pt_p.push_back(cur_pls);
            pt_i.push_back(indx_set);
            pt_f.push_back(f_source);
            upd_cnt++;
            cur_pls = 0;
        end
        if (pls) cur_pls++;
    end

    task automatic clear_mon();
        pt_i.delete();
        pt_f.delete();
        pt_p.delete();
        upd_cnt  = 0;
        done_cnt = 0;
        cur_pls  = 0;
    endtask

    task automatic set_cfg(input int il, input int ih, input int is, input int fl,
                           input int fh, input int fs, input int dw);
        indx_lo   = 8'(il);
        indx_hi   = 8'(ih);
        indx_step = 8'(is);
        f_lo      = 16'(fl);
        f_hi      = 16'(fh);
        f_step    = 16'(fs);
        dwell_len = DW'(dw);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (busy === 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_timeout_busy"}, busy, 0);
    endtask

    task automatic verify(input string tag, input int n, input int dw);
        check({tag, "_upd_cnt"}, upd_cnt, n);
        check({tag, "_done_cnt"}, done_cnt, 1);
        for (int i = 0; i < n && i < pt_i.size(); i++) begin
            check($sformatf("%s_pt%0d_indx", tag, i), pt_i[i], exp_i[i]);
            check($sformatf("%s_pt%0d_f", tag, i), pt_f[i], exp_f[i]);
        end
        check({tag, "_pls_records"}, pt_p.size(), n);
        for (int i = 0; i < pt_p.size(); i++) begin
            check($sformatf("%s_pt%0d_pls", tag, i), pt_p[i], dw);
        end
        check({tag, "_final_indx"}, indx_set, exp_i[n-1]);
        check({tag, "_final_f"}, f_source, exp_f[n-1]);
    endtask

    task automatic exp_basic();
        exp_i = '{10, 20, 30, 10, 20, 30};
        exp_f = '{100, 100, 100, 200, 200, 200};
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_indx", indx_set, 0);
        check("rst_f", f_source, 0);
        check("rst_upd", upd, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        // Basic two-axis sweep
        pls_period = 10;
        set_cfg(10, 30, 10, 100, 200, 100, 2);
        clear_mon();
        pulse_start();
        wait_idle(2000, "basic");
        exp_basic();
        verify("basic", 6, 2);

        // Index sum must not wrap past 255
        set_cfg(250, 255, 10, 5, 5, 1, 1);
        clear_mon();
        pulse_start();
        wait_idle(2000, "ovf");
        exp_i = '{250};
        exp_f = '{5};
        verify("ovf", 1, 1);

        // Inverted index range: single point
        set_cfg(40, 30, 10, 100, 200, 100, 1);
        clear_mon();
        pulse_start();
        wait_idle(2000, "inv");
        exp_i = '{40};
        exp_f = '{100};
        verify("inv", 1, 1);

        // Abort one clk after the second update
        set_cfg(10, 30, 10, 100, 200, 100, 2);
        clear_mon();
        pulse_start();
        for (int k = 0; k < 2000 && upd_cnt < 2; k++) @(negedge clk);
        check("abort_reach_upd2", upd_cnt, 2);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_indx", indx_set, 20);
        check("abort_f", f_source, 100);
        check("abort_upd", upd, 0);
        repeat (40) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        check("abort_no_more_upd", upd_cnt, 2);

        // start and abort together in IDLE
        clear_mon();
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        repeat (5) @(negedge clk);
        check("sa_busy", busy, 0);
        check("sa_upd", upd_cnt, 0);

        // Reset in the middle of a dwell, then a clean full sweep
        clear_mon();
        pulse_start();
        for (int k = 0; k < 2000 && upd_cnt < 1; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("mid_busy_before_rst", busy, 1);
        @(posedge clk); #1 rst = 1'b1; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 rst = 1'b0; start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("mid_rst_indx", indx_set, 0);
        check("mid_rst_f", f_source, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_upd", upd, 0);
        check("mid_rst_done", done, 0);
        clear_mon();
        pulse_start();
        wait_idle(2000, "rerun");
        exp_basic();
        verify("rerun", 6, 2);

        // dwell_len 0, step 0, slow pls; inputs changed mid-sweep are ignored
        pls_period = 250;
        set_cfg(1, 2, 0, 7, 7, 0, 0);
        clear_mon();
        pulse_start();
        @(posedge clk); #1;
        f_hi   = 16'd500;
        f_step = 16'd3;
        wait_idle(3000, "dw0");
        exp_i = '{1, 2};
        exp_f = '{7, 7};
        verify("dw0", 2, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
